zap_ptw_arbiter: RTL and testbench
==================================

# zap_ptw_arbiter

Two-port Wishbone arbiter that lets the instruction-side and data-side page-table walkers share one read-only descriptor-fetch bus. It sits between the two walker FSMs and the memory-side Wishbone master.
- A grant is held for the full `cyc` span of a walk access, so one requester's fetch is never interleaved with the other's.
- Grants alternate round-robin between the two requesters.
- Requester inputs are the walkers' `*_nxt` signals. Once a requester is granted, the registered bus outputs equal its own registered Wishbone signals, so the arbiter adds zero cycles.

## Interface
- TIMEOUT_CYCLES, 1024: cycles with `stb` high and no ack before the watchdog fires. Must be ≥2. Used only with the macro.
- i_clk  in  1  clock
- i_reset  in  1  reset; synchronous, active-high; clock i_clk
- i_c0_wb_cyc_nxt / i_c1_wb_cyc_nxt  in  1  requester 0 (I-walker) / 1 (D-walker) cycle request, next-state value
- i_c0_wb_stb_nxt / i_c1_wb_stb_nxt  in  1  strobe, next-state value
- i_c0_wb_adr_nxt / i_c1_wb_adr_nxt  in  32  descriptor address, next-state value
- i_c0_wb_sel_nxt / i_c1_wb_sel_nxt  in  4  byte select, next-state value
- o_c0_wb_ack / o_c1_wb_ack  out  1  ack routed to that requester
- o_c0_wb_dat / o_c1_wb_dat  out  32  read data, broadcast from i_wb_dat
- o_wb_cyc, o_wb_stb  out  1  bus cycle / strobe, registered
- o_wb_adr  out  32  bus address, registered
- o_wb_sel  out  4  bus select, registered
- o_wb_wen  out  1  tied 0
- i_wb_ack  in  1  bus ack
- i_wb_dat  in  32  bus read data
- o_gnt  out  2  one-hot current grant; 00 when idle
- o_timeout  out  1  one-cycle watchdog pulse
- o_timeout_sticky  out  1  watchdog fired since reset

## Operation
- State machine states: IDLE, GNT0, GNT1. `last_ff` records the most recent grantee.
- **IDLE:** if exactly one `cyc_nxt` is high, grant that requester. If both are high, grant the requester that is not `last_ff`.
  - On the grant edge: load `o_wb_*` from the winner's `*_nxt` signals, move to GNTn, and set `last_ff` to n.
- **GNTn:** each cycle, `o_wb_*` is loaded from requester n's `*_nxt` signals.
- **Release:** when requester n's `cyc_nxt` = 0, the state leaves GNTn.
  - If the other requester's `cyc_nxt` is high on that same edge, grant it directly: load its `*_nxt` and go to GNTother, with no idle bubble.
  - Otherwise go to IDLE and drive all `o_wb_*` to 0.
- **Ack routing:** `o_cn_wb_ack` = `i_wb_ack & o_wb_stb & gnt[n]`.
  - The non-granted requester sees ack 0, so it holds its request; its `cyc_nxt` stays high.
  - An ack arriving in IDLE or while `o_wb_stb` = 0 is discarded.
- **Read data:** `i_wb_dat` goes to both `o_cn_wb_dat`, combinationally.

## Timing
- **Reset values:** state IDLE, `last_ff` = 1 (requester 0 wins the first tie), `o_wb_cyc`/`o_wb_stb`/`o_wb_adr`/`o_wb_sel` = 0, `o_gnt` = 00, `o_timeout` = 0, `o_timeout_sticky` = 0, watchdog count = 0.
- **Reset mid-operation:** the transfer is abandoned and `cyc` drops on the next cycle. No ack is forwarded in the reset cycle.
- **Latency:**
  - Request to bus: `o_wb_cyc` rises the edge after `cyc_nxt` is seen, i.e. the same edge the requester's own `cyc_ff` rises.
  - Ack to requester: combinational, 0 cycles.
- **Grant changes:** only on an edge where the current owner's `cyc_nxt` = 0. `o_gnt` is a registered copy of the state.
- **Loser wait:** a requester that loses a tie waits the full walk access of the winner, then gets the bus on the release edge.

## Configuration
- **Macro `ZAP_PTW_ARB_TIMEOUT_EN` defined:**
  - The watchdog counts cycles with `o_wb_stb` = 1 and `i_wb_ack` = 0. It clears on ack, on `stb` low, or on a grant change.
  - When the count reaches TIMEOUT_CYCLES−1, it asserts `o_timeout` for one cycle, sets `o_timeout_sticky`, and forces a synthetic ack to the granted requester with `o_cn_wb_dat` = 0, all in that same cycle.
  - The next edge drives `o_wb_stb` = 0. The requester then continues normally.
- **Macro not defined:** there is no counter, `o_timeout` and `o_timeout_sticky` are tied 0, and TIMEOUT_CYCLES is ignored.

## Structure
- Package `zap_ptw_arb_pkg`: state typedef enum {IDLE, GNT0, GNT1}, and requester index constants REQ_I = 0, REQ_D = 1.
- Sub-module `zap_ptw_arb_wdt`: the watchdog counter with parameter TIMEOUT_CYCLES. It is instantiated only under `ZAP_PTW_ARB_TIMEOUT_EN`.

## Test plan
- **Single requester:** c0 asserts `cyc_nxt`/`stb_nxt` with adr 0x0000_4008 and sel 0xF. Next cycle `o_wb_adr` = 0x0000_4008 and `o_gnt` = 01. Ack at cycle 3 appears on `o_c0_wb_ack` only. When c0's `cyc_nxt` falls, the state returns to IDLE.
- **Simultaneous requests after reset:** c0 and c1 request in the same cycle. c0 is granted. c1 holds and is granted on the edge where c0 drops `cyc_nxt`, with no idle cycle. `o_gnt` goes 01 → 10.
- **Round-robin fairness:** c0 and c1 request continuously for 6 accesses each. The grant sequence alternates 0,1,0,1…, and neither requester waits for more than one access.
- **Spurious ack:** `i_wb_ack` pulses while IDLE, and again while granted but `stb` = 0. Both `o_cn_wb_ack` stay 0 and the state is unchanged.
- **Reset mid-walk:** c1 is granted with `stb` high, then reset asserts. The next cycle all `o_wb_*` = 0 and `o_gnt` = 00. After reset, c0 wins a tie.
- **Watchdog (macro on, TIMEOUT_CYCLES = 8):** c0 requests and the bus never acks. On the 8th `stb` cycle, `o_timeout` = 1 for one cycle and `o_c0_wb_ack` = 1 with dat 0. `o_timeout_sticky` stays 1. With the macro off, `stb` stays asserted indefinitely.

Source files
------------

// File: rtl/zap_ptw_arb_pkg.sv
// Shared types for the page-table-walker bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package zap_ptw_arb_pkg;

    // Arbiter ownership state; GNTn means requester n owns the bus.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // Requester indices: instruction-side walker and data-side walker.
    localparam int REQ_I = 0;
    localparam int REQ_D = 1;

    // One requester's next-state Wishbone read request.
    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic [31:0] adr;
        logic [3:0]  sel;
    } wb_req_t;

    localparam wb_req_t WB_REQ_IDLE = '{cyc: 1'b0, stb: 1'b0, adr: 32'd0, sel: 4'd0};

endpackage

// File: rtl/zap_ptw_arb_wdt.sv
// Watchdog: fires when the granted strobe has gone TIMEOUT_CYCLES cycles without an ack.
// Latency: o_fire is combinational in the TIMEOUT_CYCLES-th unacked strobe cycle; sticky follows one edge later.
// Backpressure: none; it only observes the bus and never stalls it.
module zap_ptw_arb_wdt #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_stb,
    input  logic i_ack,
    input  logic i_clr,
    output logic o_fire,
    output logic o_sticky
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_ff;

    // Fire in the last allowed cycle so the synthetic ack lands in that same cycle.
    assign o_fire = i_stb & ~i_ack & (cnt_ff == CNT_MAX);

    // Count unacked strobe cycles; any ack, idle strobe, owner change or firing restarts the count.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_ff   <= '0;
            o_sticky <= 1'b0;
        end else begin
            if (!i_stb || i_ack || i_clr || o_fire)
                cnt_ff <= '0;
            else
                cnt_ff <= cnt_ff + 1'b1;
            if (o_fire)
                o_sticky <= 1'b1;
        end
    end

endmodule

// File: rtl/zap_ptw_arbiter.sv
// Round-robin arbiter sharing one read-only Wishbone bus between the I- and D-side walkers.
// Latency: zero added cycles; bus outputs are registered from the owner's *_nxt, ack is routed combinationally.
// Backpressure: the losing requester sees no ack and holds its request until the owner drops cyc.
// Optional watchdog enabled by macro ZAP_PTW_ARB_TIMEOUT_EN.
module zap_ptw_arbiter
    import zap_ptw_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_c0_wb_cyc_nxt,
    input  logic        i_c0_wb_stb_nxt,
    input  logic [31:0] i_c0_wb_adr_nxt,
    input  logic [3:0]  i_c0_wb_sel_nxt,
    input  logic        i_c1_wb_cyc_nxt,
    input  logic        i_c1_wb_stb_nxt,
    input  logic [31:0] i_c1_wb_adr_nxt,
    input  logic [3:0]  i_c1_wb_sel_nxt,
    output logic        o_c0_wb_ack,
    output logic [31:0] o_c0_wb_dat,
    output logic        o_c1_wb_ack,
    output logic [31:0] o_c1_wb_dat,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic [31:0] o_wb_adr,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_wen,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_dat,
    output logic [1:0]  o_gnt,
    output logic        o_timeout,
    output logic        o_timeout_sticky
);

    wb_req_t    c0_req;
    wb_req_t    c1_req;
    wb_req_t    bus_ff;
    arb_state_t state_ff;
    logic       last_ff;
    logic [1:0] gnt_ff;
    logic       tmo;
    logic       gnt_chg;
    logic       ack_src;
    logic [31:0] rd_dat;

    assign c0_req = '{cyc: i_c0_wb_cyc_nxt, stb: i_c0_wb_stb_nxt, adr: i_c0_wb_adr_nxt, sel: i_c0_wb_sel_nxt};
    assign c1_req = '{cyc: i_c1_wb_cyc_nxt, stb: i_c1_wb_stb_nxt, adr: i_c1_wb_adr_nxt, sel: i_c1_wb_sel_nxt};

    assign o_wb_cyc = bus_ff.cyc;
    assign o_wb_stb = bus_ff.stb;
    assign o_wb_adr = bus_ff.adr;
    assign o_wb_sel = bus_ff.sel;
    assign o_wb_wen = 1'b0;
    assign o_gnt    = gnt_ff;

    // The owner releasing on this edge means ownership is about to change.
    assign gnt_chg = ((state_ff == GNT0) & ~i_c0_wb_cyc_nxt) |
                     ((state_ff == GNT1) & ~i_c1_wb_cyc_nxt);

`ifdef ZAP_PTW_ARB_TIMEOUT_EN
    zap_ptw_arb_wdt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdt (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_stb    (bus_ff.stb),
        .i_ack    (i_wb_ack),
        .i_clr    (gnt_chg),
        .o_fire   (tmo),
        .o_sticky (o_timeout_sticky)
    );
    // A watchdog-forced ack carries zero data so the walker sees an invalid descriptor.
    assign rd_dat = tmo ? 32'd0 : i_wb_dat;
`else
    assign tmo              = 1'b0;
    assign o_timeout_sticky = 1'b0;
    assign rd_dat           = i_wb_dat;
`endif

    assign o_timeout = tmo & ~i_reset;

    // Acks are only meaningful while a strobe is out; the reset cycle forwards nothing.
    assign ack_src     = (i_wb_ack | tmo) & bus_ff.stb & ~i_reset;
    assign o_c0_wb_ack = ack_src & gnt_ff[REQ_I];
    assign o_c1_wb_ack = ack_src & gnt_ff[REQ_D];
    assign o_c0_wb_dat = rd_dat;
    assign o_c1_wb_dat = rd_dat;

    // Ownership FSM: track the owner's *_nxt each cycle, hand over directly on release.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_ff <= IDLE;
            last_ff  <= 1'b1;
            bus_ff   <= WB_REQ_IDLE;
            gnt_ff   <= 2'b00;
        end else begin
            case (state_ff)
                IDLE: begin
                    if (c0_req.cyc && (!c1_req.cyc || last_ff)) begin
                        state_ff <= GNT0;
                        last_ff  <= 1'b0;
                        bus_ff   <= c0_req;
                        gnt_ff   <= 2'b01;
                    end else if (c1_req.cyc) begin
                        state_ff <= GNT1;
                        last_ff  <= 1'b1;
                        bus_ff   <= c1_req;
                        gnt_ff   <= 2'b10;
                    end else begin
                        bus_ff   <= WB_REQ_IDLE;
                        gnt_ff   <= 2'b00;
                    end
                end
                GNT0: begin
                    if (c0_req.cyc) begin
                        bus_ff <= c0_req;
                        if (tmo)
                            bus_ff.stb <= 1'b0;
                    end else if (c1_req.cyc) begin
                        state_ff <= GNT1;
                        last_ff  <= 1'b1;
                        bus_ff   <= c1_req;
                        gnt_ff   <= 2'b10;
                    end else begin
                        state_ff <= IDLE;
                        bus_ff   <= WB_REQ_IDLE;
                        gnt_ff   <= 2'b00;
                    end
                end
                GNT1: begin
                    if (c1_req.cyc) begin
                        bus_ff <= c1_req;
                        if (tmo)
                            bus_ff.stb <= 1'b0;
                    end else if (c0_req.cyc) begin
                        state_ff <= GNT0;
                        last_ff  <= 1'b0;
                        bus_ff   <= c0_req;
                        gnt_ff   <= 2'b01;
                    end else begin
                        state_ff <= IDLE;
                        bus_ff   <= WB_REQ_IDLE;
                        gnt_ff   <= 2'b00;
                    end
                end
                default: begin
                    state_ff <= IDLE;
                    bus_ff   <= WB_REQ_IDLE;
                    gnt_ff   <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zap_ptw_arbiter.sv
// Directed self-checking bench for the walker bus arbiter.
// Latency: expectations assume registered bus outputs one edge after *_nxt and combinational ack.
// Backpressure: the bench plays both walkers, holding requests until acked and granted.
module tb_zap_ptw_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        c0_cyc, c0_stb, c1_cyc, c1_stb;
    logic [31:0] c0_adr, c1_adr;
    logic [3:0]  c0_sel, c1_sel;
    logic        o_c0_wb_ack, o_c1_wb_ack;
    logic [31:0] o_c0_wb_dat, o_c1_wb_dat;
    logic        o_wb_cyc, o_wb_stb, o_wb_wen;
    logic [31:0] o_wb_adr;
    logic [3:0]  o_wb_sel;
    logic        i_wb_ack;
    logic [31:0] i_wb_dat;
    logic [1:0]  o_gnt;
    logic        o_timeout, o_timeout_sticky;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    zap_ptw_arbiter #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_c0_wb_cyc_nxt  (c0_cyc),
        .i_c0_wb_stb_nxt  (c0_stb),
        .i_c0_wb_adr_nxt  (c0_adr),
        .i_c0_wb_sel_nxt  (c0_sel),
        .i_c1_wb_cyc_nxt  (c1_cyc),
        .i_c1_wb_stb_nxt  (c1_stb),
        .i_c1_wb_adr_nxt  (c1_adr),
        .i_c1_wb_sel_nxt  (c1_sel),
        .o_c0_wb_ack      (o_c0_wb_ack),
        .o_c0_wb_dat      (o_c0_wb_dat),
        .o_c1_wb_ack      (o_c1_wb_ack),
        .o_c1_wb_dat      (o_c1_wb_dat),
        .o_wb_cyc         (o_wb_cyc),
        .o_wb_stb         (o_wb_stb),
        .o_wb_adr         (o_wb_adr),
        .o_wb_sel         (o_wb_sel),
        .o_wb_wen         (o_wb_wen),
        .i_wb_ack         (i_wb_ack),
        .i_wb_dat         (i_wb_dat),
        .o_gnt            (o_gnt),
        .o_timeout        (o_timeout),
        .o_timeout_sticky (o_timeout_sticky)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1ns after it, away from the sampling edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_c0(input logic cyc, input logic stb, input logic [31:0] adr, input logic [3:0] sel);
        c0_cyc = cyc; c0_stb = stb; c0_adr = adr; c0_sel = sel;
    endtask

    task automatic set_c1(input logic cyc, input logic stb, input logic [31:0] adr, input logic [3:0] sel);
        c1_cyc = cyc; c1_stb = stb; c1_adr = adr; c1_sel = sel;
    endtask

    initial begin
        i_reset  = 1'b1;
        i_wb_ack = 1'b0;
        i_wb_dat = 32'h0;
        set_c0(1'b0, 1'b0, 32'h0, 4'h0);
        set_c1(1'b0, 1'b0, 32'h0, 4'h0);
        step();
        step();
        i_reset = 1'b0;

        // Reset values
        check("rst_cyc", {31'd0, o_wb_cyc}, 32'd0);
        check("rst_stb", {31'd0, o_wb_stb}, 32'd0);
        check("rst_adr", o_wb_adr, 32'd0);
        check("rst_sel", {28'd0, o_wb_sel}, 32'd0);
        check("rst_gnt", {30'd0, o_gnt}, 32'd0);
        check("rst_tmo", {31'd0, o_timeout}, 32'd0);
        check("rst_sticky", {31'd0, o_timeout_sticky}, 32'd0);
        check("wen_tied", {31'd0, o_wb_wen}, 32'd0);

        // Simultaneous requests after reset: c0 wins, c1 follows with no bubble
        set_c0(1'b1, 1'b1, 32'h0000_1000, 4'hF);
        set_c1(1'b1, 1'b1, 32'h0000_2000, 4'hC);
        step();
        check("tie_gnt0", {30'd0, o_gnt}, 32'd1);
        check("tie_adr0", o_wb_adr, 32'h0000_1000);
        step();
        check("tie_hold", {30'd0, o_gnt}, 32'd1);
        i_wb_ack = 1'b1; i_wb_dat = 32'hCAFE_0001;
        #1;
        check("tie_ack0", {31'd0, o_c0_wb_ack}, 32'd1);
        check("tie_noack1", {31'd0, o_c1_wb_ack}, 32'd0);
        i_wb_ack = 1'b0;
        set_c0(1'b0, 1'b0, 32'h0, 4'h0);
        step();
        check("tie_gnt1", {30'd0, o_gnt}, 32'd2);
        check("tie_cyc1", {31'd0, o_wb_cyc}, 32'd1);
        check("tie_adr1", o_wb_adr, 32'h0000_2000);
        check("tie_sel1", {28'd0, o_wb_sel}, 32'hC);
        i_wb_ack = 1'b1;
        #1;
        check("tie_ack1", {31'd0, o_c1_wb_ack}, 32'd1);
        check("tie_noack0", {31'd0, o_c0_wb_ack}, 32'd0);
        i_wb_ack = 1'b0;
        set_c1(1'b0, 1'b0, 32'h0, 4'h0);
        step();
        check("tie_idle", {30'd0, o_gnt}, 32'd0);

        // Single requester
        set_c0(1'b1, 1'b1, 32'h0000_4008, 4'hF);
        step();
        check("single_adr", o_wb_adr, 32'h0000_4008);
        check("single_sel", {28'd0, o_wb_sel}, 32'hF);
        check("single_gnt", {30'd0, o_gnt}, 32'd1);
        step();
        i_wb_ack = 1'b1; i_wb_dat = 32'hDEAD_BEEF;
        #1;
        check("single_ack0", {31'd0, o_c0_wb_ack}, 32'd1);
        check("single_ack1", {31'd0, o_c1_wb_ack}, 32'd0);
        check("single_dat0", o_c0_wb_dat, 32'hDEAD_BEEF);
        check("single_dat1", o_c1_wb_dat, 32'hDEAD_BEEF);
        i_wb_ack = 1'b0;
        set_c0(1'b0, 1'b0, 32'h0, 4'h0);
        step();
        check("single_rel_cyc", {31'd0, o_wb_cyc}, 32'd0);
        check("single_rel_gnt", {30'd0, o_gnt}, 32'd0);
        check("single_rel_adr", o_wb_adr, 32'd0);

        // Spurious acks: in IDLE, then while granted with stb low
        i_wb_ack = 1'b1;
        #1;
        check("spur_idle_ack0", {31'd0, o_c0_wb_ack}, 32'd0);
        check("spur_idle_ack1", {31'd0, o_c1_wb_ack}, 32'd0);
        step();
        check("spur_idle_gnt", {30'd0, o_gnt}, 32'd0);
        i_wb_ack = 1'b0;
        set_c1(1'b1, 1'b0, 32'h0000_0100, 4'h3);
        step();
        check("spur_gnt1", {30'd0, o_gnt}, 32'd2);
        check("spur_stb0", {31'd0, o_wb_stb}, 32'd0);
        i_wb_ack = 1'b1;
        #1;
        check("spur_nostb_ack1", {31'd0, o_c1_wb_ack}, 32'd0);
        step();
        check("spur_gnt_kept", {30'd0, o_gnt}, 32'd2);
        i_wb_ack = 1'b0;
        set_c1(1'b0, 1'b0, 32'h0, 4'h0);
        step();
        check("spur_idle2", {30'd0, o_gnt}, 32'd0);

        // Round-robin: both request continuously; last grantee was c1, so c0 starts
        set_c0(1'b1, 1'b1, 32'h0000_00A0, 4'hF);
        set_c1(1'b1, 1'b1, 32'h0000_00B0, 4'hF);
        step();
        for (int i = 0; i < 12; i++) begin
            int owner;
            owner = i % 2;
            check($sformatf("rr_gnt_%0d", i), {30'd0, o_gnt}, (owner == 0) ? 32'd1 : 32'd2);
            check($sformatf("rr_adr_%0d", i), o_wb_adr, (owner == 0) ? 32'h0000_00A0 : 32'h0000_00B0);
            i_wb_ack = 1'b1;
            #1;
            check($sformatf("rr_ack_%0d", i), {31'd0, (owner == 0) ? o_c0_wb_ack : o_c1_wb_ack}, 32'd1);
            check($sformatf("rr_noack_%0d", i), {31'd0, (owner == 0) ? o_c1_wb_ack : o_c0_wb_ack}, 32'd0);
            i_wb_ack = 1'b0;
            if (owner == 0) set_c0(1'b0, 1'b0, 32'h0, 4'h0);
            else            set_c1(1'b0, 1'b0, 32'h0, 4'h0);
            step();
            if (owner == 0) set_c0(1'b1, 1'b1, 32'h0000_00A0, 4'hF);
            else            set_c1(1'b1, 1'b1, 32'h0000_00B0, 4'hF);
        end
        check("rr_after_gnt", {30'd0, o_gnt}, 32'd1);
        set_c0(1'b0, 1'b0, 32'h0, 4'h0);
        set_c1(1'b0, 1'b0, 32'h0, 4'h0);
        step();
        check("rr_idle", {30'd0, o_gnt}, 32'd0);

        // Reset mid-walk while c1 owns the bus
        set_c1(1'b1, 1'b1, 32'h0000_5000, 4'hF);
        step();
        check("rmw_gnt1", {30'd0, o_gnt}, 32'd2);
        check("rmw_stb", {31'd0, o_wb_stb}, 32'd1);
        i_reset = 1'b1; i_wb_ack = 1'b1;
        #1;
        check("rmw_noack", {31'd0, o_c1_wb_ack}, 32'd0);
        step();
        check("rmw_cyc", {31'd0, o_wb_cyc}, 32'd0);
        check("rmw_stb0", {31'd0, o_wb_stb}, 32'd0);
        check("rmw_adr", o_wb_adr, 32'd0);
        check("rmw_sel", {28'd0, o_wb_sel}, 32'd0);
        check("rmw_gnt", {30'd0, o_gnt}, 32'd0);
        i_reset = 1'b0; i_wb_ack = 1'b0;
        set_c0(1'b1, 1'b1, 32'h0000_6000, 4'hF);
        step();
        check("rmw_tie_c0", {30'd0, o_gnt}, 32'd1);
        set_c0(1'b0, 1'b0, 32'h0, 4'h0);
        set_c1(1'b0, 1'b0, 32'h0, 4'h0);
        step();
        check("rmw_idle", {30'd0, o_gnt}, 32'd0);

        // Watchdog: c0 strobes and the bus never acks
        i_wb_dat = 32'h1234_5678;
        set_c0(1'b1, 1'b1, 32'h0000_7000, 4'hF);
        step();
        for (int k = 1; k < 8; k++) begin
            check($sformatf("wdt_quiet_%0d", k), {31'd0, o_timeout}, 32'd0);
            check($sformatf("wdt_noack_%0d", k), {31'd0, o_c0_wb_ack}, 32'd0);
            step();
        end
`ifdef ZAP_PTW_ARB_TIMEOUT_EN
        check("wdt_fire", {31'd0, o_timeout}, 32'd1);
        check("wdt_ack0", {31'd0, o_c0_wb_ack}, 32'd1);
        check("wdt_ack1", {31'd0, o_c1_wb_ack}, 32'd0);
        check("wdt_dat0", o_c0_wb_dat, 32'd0);
        step();
        check("wdt_stb_drop", {31'd0, o_wb_stb}, 32'd0);
        check("wdt_cyc_kept", {31'd0, o_wb_cyc}, 32'd1);
        check("wdt_pulse_end", {31'd0, o_timeout}, 32'd0);
        check("wdt_sticky", {31'd0, o_timeout_sticky}, 32'd1);
        set_c0(1'b0, 1'b0, 32'h0, 4'h0);
        step();
        check("wdt_sticky_hold", {31'd0, o_timeout_sticky}, 32'd1);
        check("wdt_idle", {30'd0, o_gnt}, 32'd0);
`else
        check("nowdt_tmo", {31'd0, o_timeout}, 32'd0);
        check("nowdt_ack0", {31'd0, o_c0_wb_ack}, 32'd0);
        check("nowdt_dat0", o_c0_wb_dat, 32'h1234_5678);
        for (int k = 0; k < 12; k++) step();
        check("nowdt_stb_held", {31'd0, o_wb_stb}, 32'd1);
        check("nowdt_sticky", {31'd0, o_timeout_sticky}, 32'd0);
        set_c0(1'b0, 1'b0, 32'h0, 4'h0);
        step();
        check("nowdt_idle", {30'd0, o_gnt}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
